// File: rtl/ad9910_cfg_seq.sv
// ad9910_cfg_seq: AD9910 register-write sequencer feeding the byte-level SPI master.
// Walks the init table on start, then serves Profile 0 FTW rewrites.
// Optional macro AD9910_READBACK_EN: after init, read CFR1 back and flag a mismatch on cfg_err.
//
// state   | meaning
// IDLE    | waiting for start or a pending FTW rewrite
// LOAD    | latch the next frame into the byte shifter, raise cs_hold
// SEND    | hand one byte to the SPI master (spi_en pulse)
// WAIT    | wait for spi_done of the current byte
// GAP     | cs_hold low between register frames
// IOUPD   | io_update pulse
// DONE    | single-cycle completion, sets cfg_done after init
// RB_SEND | issue one byte of the CFR1 read frame
// RB_WAIT | wait for spi_done, capture spi_rdata
module ad9910_cfg_seq #(
  parameter int          IOUPD_CYCLES = 8,
  parameter int          GAP_CYCLES   = 4,
  parameter logic [15:0] ASF_DEFAULT  = 16'h3FFF
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        start,
  input  logic [31:0] ftw_in,
  input  logic        ftw_wr,
  output logic        spi_en,
  output logic [7:0]  spi_sdata,
  input  logic [7:0]  spi_rdata,
  input  logic        spi_done,
  output logic        cs_hold,
  output logic        io_update,
  output logic        busy,
  output logic        cfg_done,
  output logic        cfg_err
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_LOAD  = 4'd1;
  localparam logic [3:0] S_SEND  = 4'd2;
  localparam logic [3:0] S_WAIT  = 4'd3;
  localparam logic [3:0] S_GAP   = 4'd4;
  localparam logic [3:0] S_IOUPD = 4'd5;
  localparam logic [3:0] S_DONE  = 4'd6;
`ifdef AD9910_READBACK_EN
  localparam logic [3:0] S_RB_SEND = 4'd7;
  localparam logic [3:0] S_RB_WAIT = 4'd8;
`endif

  // Entries 0..4 are the init table; entry 5 is the run-time FTW frame.
  localparam logic [2:0] LAST_INIT = 3'd4;
  localparam logic [2:0] FTW_ENTRY = 3'd5;

  logic [3:0]  state;
  logic [2:0]  entry;
  logic [71:0] shreg;
  logic [3:0]  bytes_left;
  logic [15:0] tmr;
  logic        ftw_pend;
  logic [31:0] ftw_val;
  logic [31:0] ftw_cur;
  logic [71:0] frame;
  logic [3:0]  frame_len;

`ifdef AD9910_READBACK_EN
  logic [2:0]  rb_cnt;
  logic [31:0] rb_word;
`else
  logic        unused_rdata;
  assign unused_rdata = ^spi_rdata;
  assign cfg_err      = 1'b0;
`endif

  assign busy = (state != S_IDLE);

  // Frame contents, left-justified: instruction byte then data MSB first.
  always_comb begin
    frame     = '0;
    frame_len = 4'd4;
    case (entry)
      3'd0: frame = {8'h00, 32'h00000002, 32'h0};
      3'd1: frame = {8'h01, 32'h01400820, 32'h0};
      3'd2: frame = {8'h02, 32'h053F4132, 32'h0};
      3'd3: frame = {8'h03, 32'h0000007F, 32'h0};
      3'd4: begin
        frame     = {8'h0E, ASF_DEFAULT, 16'h0000, 32'h19999999};
        frame_len = 4'd8;
      end
      default: begin
        frame     = {8'h0E, ASF_DEFAULT, 16'h0000, ftw_cur};
        frame_len = 4'd8;
      end
    endcase
  end

  // Sequencer FSM, byte shifter, timers and the pending-FTW latch.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= S_IDLE;
      entry      <= 3'd0;
      shreg      <= '0;
      bytes_left <= 4'd0;
      tmr        <= 16'd0;
      ftw_pend   <= 1'b0;
      ftw_val    <= 32'd0;
      ftw_cur    <= 32'd0;
      spi_en     <= 1'b0;
      spi_sdata  <= 8'h00;
      cs_hold    <= 1'b0;
      io_update  <= 1'b0;
      cfg_done   <= 1'b0;
`ifdef AD9910_READBACK_EN
      cfg_err    <= 1'b0;
      rb_cnt     <= 3'd0;
      rb_word    <= 32'd0;
`endif
    end else begin
      spi_en <= 1'b0;
      if (ftw_wr) begin
        ftw_pend <= 1'b1;
        ftw_val  <= ftw_in;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            entry    <= 3'd0;
            cfg_done <= 1'b0;
`ifdef AD9910_READBACK_EN
            cfg_err  <= 1'b0;
`endif
            state    <= S_LOAD;
          end else if (ftw_pend && cfg_done) begin
            entry   <= FTW_ENTRY;
            ftw_cur <= ftw_val;
            // A write landing in this very cycle stays pending for the next frame.
            if (!ftw_wr) ftw_pend <= 1'b0;
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          shreg      <= frame;
          bytes_left <= frame_len;
          cs_hold    <= 1'b1;
          state      <= S_SEND;
        end
        S_SEND: begin
          spi_en    <= 1'b1;
          spi_sdata <= shreg[71:64];
          shreg     <= {shreg[63:0], 8'h00};
          state     <= S_WAIT;
        end
        S_WAIT: begin
          if (spi_done) begin
            if (bytes_left == 4'd0) begin
              cs_hold <= 1'b0;
              tmr     <= 16'(GAP_CYCLES - 1);
              state   <= S_GAP;
            end else begin
              bytes_left <= bytes_left - 4'd1;
              state      <= S_SEND;
            end
          end
        end
        S_GAP: begin
          if (tmr == 16'd0) begin
            if (entry >= LAST_INIT) begin
              io_update <= 1'b1;
              tmr       <= 16'(IOUPD_CYCLES - 1);
              state     <= S_IOUPD;
            end else begin
              entry <= entry + 3'd1;
              state <= S_LOAD;
            end
          end else begin
            tmr <= tmr - 16'd1;
          end
        end
        S_IOUPD: begin
          if (tmr == 16'd0) begin
            io_update <= 1'b0;
`ifdef AD9910_READBACK_EN
            if (entry == LAST_INIT) begin
              cs_hold <= 1'b1;
              rb_cnt  <= 3'd0;
              state   <= S_RB_SEND;
            end else begin
              state <= S_DONE;
            end
`else
            state <= S_DONE;
`endif
          end else begin
            tmr <= tmr - 16'd1;
          end
        end
        S_DONE: begin
          if (entry == LAST_INIT) cfg_done <= 1'b1;
          state <= S_IDLE;
        end
`ifdef AD9910_READBACK_EN
        S_RB_SEND: begin
          spi_en    <= 1'b1;
          spi_sdata <= (rb_cnt == 3'd0) ? 8'h80 : 8'h00;
          state     <= S_RB_WAIT;
        end
        S_RB_WAIT: begin
          if (spi_done) begin
            if (rb_cnt != 3'd0) rb_word <= {rb_word[23:0], spi_rdata};
            if (rb_cnt == 3'd4) begin
              cs_hold <= 1'b0;
              cfg_err <= ({rb_word[23:0], spi_rdata} != 32'h00000002);
              state   <= S_DONE;
            end else begin
              rb_cnt <= rb_cnt + 3'd1;
              state  <= S_RB_SEND;
            end
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ad9910_cfg_seq.sv
// tb_ad9910_cfg_seq: directed bench for ad9910_cfg_seq with an SPI-master model and byte scoreboard.
module tb_ad9910_cfg_seq;
  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] ftw_in = 32'd0;
  logic        ftw_wr = 1'b0;
  logic        spi_en;
  logic [7:0]  spi_sdata;
  logic [7:0]  spi_rdata = 8'h00;
  logic        spi_done = 1'b0;
  logic        cs_hold;
  logic        io_update;
  logic        busy;
  logic        cfg_done;
  logic        cfg_err;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  int en_cnt = 0, frame_cnt = 0, min_gap = 999, low_run = 0;
  int iou_run = 0, iou_w = 0, iou_pulses = 0;
  int resp_cnt = 0, resp_idx = 0, frame_byte = 0;
  logic        prev_cs = 1'b0;
  logic [31:0] miso_word = 32'h00000002;

`ifdef AD9910_READBACK_EN
  localparam int INIT_BYTES  = 34;
  localparam int INIT_FRAMES = 6;
`else
  localparam int INIT_BYTES  = 29;
  localparam int INIT_FRAMES = 5;
`endif

  ad9910_cfg_seq dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .ftw_in(ftw_in), .ftw_wr(ftw_wr),
    .spi_en(spi_en), .spi_sdata(spi_sdata), .spi_rdata(spi_rdata), .spi_done(spi_done),
    .cs_hold(cs_hold), .io_update(io_update), .busy(busy), .cfg_done(cfg_done), .cfg_err(cfg_err)
  );

  always #10 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // SPI master model + scoreboard consumer + framing statistics, all sampled on the falling edge.
  always @(negedge sys_clk) begin
    spi_done = 1'b0;
    if (sys_rst) begin
      resp_cnt = 0;
    end else if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        spi_done  = 1'b1;
        spi_rdata = (resp_idx >= 1 && resp_idx <= 4) ? miso_word[(4 - resp_idx) * 8 +: 8] : 8'h00;
      end
    end
    if (cs_hold && !prev_cs) begin
      if (frame_cnt > 0 && low_run < min_gap) min_gap = low_run;
      frame_cnt++;
      frame_byte = 0;
      low_run = 0;
    end else if (!cs_hold) begin
      low_run++;
    end
    prev_cs = cs_hold;
    if (spi_en) begin
      en_cnt++;
      check("cs_at_en", 64'(cs_hold), 64'd1);
      if (exp_q.size() == 0) check("spi_byte_extra", 64'd1, 64'd0);
      else check("spi_byte", 64'(spi_sdata), 64'(exp_q.pop_front()));
      resp_cnt   = 16;
      resp_idx   = frame_byte;
      frame_byte++;
    end
    if (io_update) iou_run++;
    else if (iou_run > 0) begin
      iou_w = iou_run;
      iou_pulses++;
      iou_run = 0;
    end
  end

  task automatic clear_stats();
    en_cnt = 0; frame_cnt = 0; min_gap = 999; iou_w = 0; iou_pulses = 0;
  endtask

  task automatic push_frame(input logic [7:0] addr, input logic [63:0] data, input int n);
    exp_q.push_back(addr);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(data[i * 8 +: 8]);
  endtask

  task automatic push_init();
    push_frame(8'h00, 64'h00000002, 4);
    push_frame(8'h01, 64'h01400820, 4);
    push_frame(8'h02, 64'h053F4132, 4);
    push_frame(8'h03, 64'h0000007F, 4);
    push_frame(8'h0E, 64'h3FFF0000_19999999, 8);
`ifdef AD9910_READBACK_EN
    push_frame(8'h80, 64'h0, 4);
`endif
  endtask

  task automatic wait_run(input string tag, input int budget);
    int n = 0;
    while (!busy && n < 20) begin @(negedge sys_clk); n++; end
    n = 0;
    while (busy && n < budget) begin @(negedge sys_clk); n++; end
    check({tag, "_timeout"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held 3 cycles with start asserted.
    sys_rst = 1'b1; start = 1'b1;
    repeat (3) @(negedge sys_clk);
    check("rst_spi_en", 64'(spi_en), 64'd0);
    check("rst_cs_hold", 64'(cs_hold), 64'd0);
    check("rst_io_update", 64'(io_update), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cfg_done", 64'(cfg_done), 64'd0);
    check("rst_cfg_err", 64'(cfg_err), 64'd0);
    check("rst_sdata", 64'(spi_sdata), 64'd0);
    check("rst_en_cnt", 64'(en_cnt), 64'd0);
    sys_rst = 1'b0; start = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("post_rst_busy", 64'(busy), 64'd0);

    // Full init sequence.
    clear_stats();
    miso_word = 32'h00000002;
    push_init();
    start = 1'b1; @(negedge sys_clk); start = 1'b0;
    wait_run("init", 5000);
    check("init_en_cnt", 64'(en_cnt), 64'(INIT_BYTES));
    check("init_frames", 64'(frame_cnt), 64'(INIT_FRAMES));
    check("init_min_gap_ge4", 64'(min_gap >= 4), 64'd1);
    check("init_iou_width", 64'(iou_w), 64'd8);
    check("init_iou_pulses", 64'(iou_pulses), 64'd1);
    check("init_cfg_done", 64'(cfg_done), 64'd1);
    check("init_cfg_err", 64'(cfg_err), 64'd0);
    check("init_q_empty", 64'(exp_q.size()), 64'd0);

    // Run-time FTW rewrite.
    clear_stats();
    push_frame(8'h0E, 64'h3FFF0000_28F5C28F, 8);
    ftw_in = 32'h28F5C28F; ftw_wr = 1'b1; @(negedge sys_clk); ftw_wr = 1'b0;
    wait_run("ftw", 1000);
    check("ftw_en_cnt", 64'(en_cnt), 64'd9);
    check("ftw_frames", 64'(frame_cnt), 64'd1);
    check("ftw_iou_width", 64'(iou_w), 64'd8);
    check("ftw_cfg_done", 64'(cfg_done), 64'd1);
    check("ftw_q_empty", 64'(exp_q.size()), 64'd0);

    // start and ftw_wr together, then an overwriting ftw_wr during init.
    clear_stats();
    push_init();
    push_frame(8'h0E, 64'h3FFF0000_22222222, 8);
    start = 1'b1; ftw_wr = 1'b1; ftw_in = 32'h11111111;
    @(negedge sys_clk);
    start = 1'b0; ftw_wr = 1'b0;
    check("pend_cfg_done_cleared", 64'(cfg_done), 64'd0);
    repeat (100) @(negedge sys_clk);
    ftw_in = 32'h22222222; ftw_wr = 1'b1; @(negedge sys_clk); ftw_wr = 1'b0;
    wait_run("pend_init", 5000);
    check("pend_init_bytes", 64'(en_cnt), 64'(INIT_BYTES));
    wait_run("pend_ftw", 1000);
    repeat (60) @(negedge sys_clk);
    check("pend_total_bytes", 64'(en_cnt), 64'(INIT_BYTES + 9));
    check("pend_frames", 64'(frame_cnt), 64'(INIT_FRAMES + 1));
    check("pend_iou_pulses", 64'(iou_pulses), 64'd2);
    check("pend_idle_after", 64'(busy), 64'd0);
    check("pend_q_empty", 64'(exp_q.size()), 64'd0);

    // Reset during WAIT of byte 7, then a fresh start.
    clear_stats();
    push_init();
    start = 1'b1; @(negedge sys_clk); start = 1'b0;
    begin
      int n = 0;
      while (en_cnt < 8 && n < 2000) begin @(negedge sys_clk); n++; end
    end
    check("abort_reached_byte7", 64'(en_cnt), 64'd8);
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("abort_cs_hold", 64'(cs_hold), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_cfg_done", 64'(cfg_done), 64'd0);
    sys_rst = 1'b0;
    exp_q.delete();
    repeat (40) @(negedge sys_clk);
    check("abort_no_more_en", 64'(en_cnt), 64'd8);
    clear_stats();
    miso_word = 32'h00000003;
    push_init();
    start = 1'b1; @(negedge sys_clk); start = 1'b0;
    wait_run("restart", 5000);
    check("restart_en_cnt", 64'(en_cnt), 64'(INIT_BYTES));
    check("restart_cfg_done", 64'(cfg_done), 64'd1);
`ifdef AD9910_READBACK_EN
    check("restart_cfg_err", 64'(cfg_err), 64'd1);
`else
    check("restart_cfg_err", 64'(cfg_err), 64'd0);
`endif
    check("restart_q_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
